mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access unit of the 5-stage pipeline. It consumes the ALU result, store data and memory controls latched by the EX/MEM register. It runs each load/store as a req/ack transaction on the data bus and stalls the pipeline until the transaction completes. It returns the aligned, extended load data toward MEM/WB, and flags misaligned accesses and bus timeouts.

## Interface
- WAIT_LIMIT, 255: maximum cycles spent in WAIT before a bus timeout is declared (1..255).

Ports:
- in_CLK  in  1  clock; all state updates on rising edge.
- in_CLR  in  1  reset; synchronous, active-high.
- in_memread  in  1  load request from EX/MEM control.
- in_memwrite  in  1  store request from EX/MEM control.
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- in_signext  in  1  load extension: 1 sign, 0 zero.
- in_R  in  32  effective address (EX/MEM ALU result).
- in_rb  in  32  store data (EX/MEM rb).
- out_stall  out  1  freeze request; drives EX/MEM in_EN low and holds upstream stages.
- out_rdata  out  32  aligned/extended load data; valid in DONE.
- out_misalign  out  1  one-cycle pulse on a misaligned or illegal-size access.
- out_buserr  out  1  one-cycle pulse on bus timeout.
- out_bus_req  out  1  bus request; registered.
- out_bus_we  out  1  1 = write.
- out_bus_addr  out  30  word address, in_R[31:2].
- out_bus_be  out  4  byte enables.
- out_bus_wdata  out  32  lane-replicated store data.
- in_bus_ack  in  1  transaction complete.
- in_bus_rdata  in  32  read data; sampled when in_bus_ack is high.

## Operation
- op = in_memread | in_memwrite. If both are high, treat it as a load.
- Alignment:
  - Aligned: byte always; half if in_R[0]=0; word if in_R[1:0]=00.
  - Size 11 is illegal.
  - Misaligned or illegal: no bus request; out_misalign pulses for one cycle; no stall.
- Byte enables:
  - Byte: be = 1<<in_R[1:0]; wdata = {4{rb[7:0]}}.
  - Half: be = in_R[1] ? 1100 : 0011; wdata = {2{rb[15:0]}}.
  - Word: be = 1111; wdata = rb.
- Load extraction:
  - Select the byte or half lane by address.
  - Sign- or zero-extend per in_signext.
  - Word loads pass through unchanged.
  - Store transactions return out_rdata = 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on an aligned op, latch addr/we/be/wdata/size/signext, set out_bus_req=1, go to WAIT. Otherwise stay.
  - WAIT: hold all bus outputs stable. Wait counter increments each cycle.
    - On in_bus_ack: capture the extracted rdata, clear req, go to DONE.
    - When the counter reaches WAIT_LIMIT without ack: clear req, out_rdata=0, pulse out_buserr, go to DONE.
  - DONE: out_rdata valid; go to IDLE unconditionally.
- out_stall (combinational) = (state==IDLE & aligned op) | state==WAIT.
- out_stall is low in DONE, so EX/MEM advances at the end of the DONE cycle.

## Timing
- Reset (in_CLR high at an edge): state IDLE, counter 0, and every output 0: out_stall (given no op), out_rdata, out_misalign, out_buserr, out_bus_req, out_bus_we, out_bus_addr, out_bus_be, out_bus_wdata.
- Minimum latency, with ack in the first WAIT cycle:
  - Cycle 0: op seen in IDLE, stall.
  - Cycle 1: WAIT, req high, ack.
  - Cycle 2: DONE, stall low.
  - Total: 2 stall cycles per access.
- Ack with latency k cycles after req rises gives 1+k stall cycles.
- in_bus_ack is ignored in IDLE and DONE.
- Ack arriving in the same cycle the counter hits WAIT_LIMIT: ack wins, no out_buserr.
- Reset mid-WAIT: req drops at that edge, the transaction is abandoned, and a later stray ack is ignored.
- Pipeline inputs are ignored outside IDLE; they are stable during a stall anyway.
- An op present in IDLE right after DONE starts a new transaction in that cycle. This covers back-to-back accesses.
- out_misalign and out_buserr are registered and high for exactly one cycle.

## Structure
- Shared package mem_pkg:
  - state encoding (IDLE=0, WAIT=1, DONE=2);
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - default WAIT_LIMIT.
- One combinational sub-module, mem_lane_align: byte enables, store-lane replication and load extraction from (addr[1:0], size, signext).
- The FSM, counter and stall logic stay in mem_access_unit.

## Test plan
- Word load from 0x100, ack 3 cycles after req → bus_addr=0x40, be=1111, stall for 4 cycles, out_rdata=in_bus_rdata during DONE.
- Signed byte load from 0x103 with rdata=0x80FFFF12 → be=1000, out_rdata=0xFFFFFF80. With in_signext=0 → 0x00000080.
- Half store of rb=0x0000BEEF to 0x202 → we=1, be=1100, wdata=0xBEEFBEEF, out_rdata=0.
- Word load from 0x101 → out_misalign one-cycle pulse, out_bus_req stays 0, out_stall 0.
- No ack with WAIT_LIMIT=4 → req held for 4 WAIT cycles, then out_buserr pulse, out_rdata=0, stall released in DONE.
- Reset asserted in the second WAIT cycle, then ack → req 0 after the edge, state IDLE, ack ignored, no DONE.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_pkg : shared types/constants for the memory access stage       |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int DEFAULT_WAIT_LIMIT = 255;

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: return 1'b1;
         SZ_HALF: return ~lo[0];
         SZ_WORD: return (lo == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_lane_align : byte enables, store lane replication, load extract |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        signext,
   input  logic [31:0] store_data,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = bus_rdata[7:0];
      case (addr_lo)
         2'd0:    byte_sel = bus_rdata[7:0];
         2'd1:    byte_sel = bus_rdata[15:8];
         2'd2:    byte_sel = bus_rdata[23:16];
         default: byte_sel = bus_rdata[31:24];
      endcase
   end

   assign half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      be        = 4'b0000;
      wdata     = 32'd0;
      load_data = 32'd0;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{signext & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{signext & half_sel[15]}}, half_sel};
         end
         SZ_WORD: begin
            be        = 4'b1111;
            wdata     = store_data;
            load_data = bus_rdata;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit : MEM-stage load/store bus master with stall/timeout|
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
   input  logic        in_CLK,
   input  logic        in_CLR,
   input  logic        in_memread,
   input  logic        in_memwrite,
   input  logic [1:0]  in_size,
   input  logic        in_signext,
   input  logic [31:0] in_R,
   input  logic [31:0] in_rb,
   output logic        out_stall,
   output logic [31:0] out_rdata,
   output logic        out_misalign,
   output logic        out_buserr,
   output logic        out_bus_req,
   output logic        out_bus_we,
   output logic [29:0] out_bus_addr,
   output logic [3:0]  out_bus_be,
   output logic [31:0] out_bus_wdata,
   input  logic        in_bus_ack,
   input  logic [31:0] in_bus_rdata
);

   localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

   state_t      state, state_nx;
   logic [7:0]  wait_cnt;
   logic        op, aligned, start, timeout, take_ack;
   logic [1:0]  lo_q, size_q;
   logic        signext_q;
   logic [1:0]  sel_lo, sel_size;
   logic        sel_sext;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, lane_load;

   assign op      = in_memread | in_memwrite;
   assign aligned = is_aligned(in_size, in_R[1:0]);
   assign start   = op & aligned;

   // Idle decodes the live request; once latched, extraction uses the held attributes.
   assign sel_lo   = (state == ST_IDLE) ? in_R[1:0]  : lo_q;
   assign sel_size = (state == ST_IDLE) ? in_size    : size_q;
   assign sel_sext = (state == ST_IDLE) ? in_signext : signext_q;

   mem_lane_align u_lane (
      .addr_lo    (sel_lo),
      .size       (sel_size),
      .signext    (sel_sext),
      .store_data (in_rb),
      .bus_rdata  (in_bus_rdata),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (lane_load)
   );

   always_ff @(posedge in_CLK) begin
      if (in_CLR) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      out_stall = 1'b0;
      take_ack  = 1'b0;
      timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               out_stall = 1'b1;
               state_nx  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            out_stall = 1'b1;
            // An ack on the limit cycle still completes normally.
            if (in_bus_ack) begin
               take_ack = 1'b1;
               state_nx = ST_DONE;
            end else if (wait_cnt == LIMIT_M1) begin
               timeout  = 1'b1;
               state_nx = ST_DONE;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_CLK) begin
      if (in_CLR) begin
         wait_cnt      <= 8'd0;
         out_rdata     <= 32'd0;
         out_misalign  <= 1'b0;
         out_buserr    <= 1'b0;
         out_bus_req   <= 1'b0;
         out_bus_we    <= 1'b0;
         out_bus_addr  <= 30'd0;
         out_bus_be    <= 4'd0;
         out_bus_wdata <= 32'd0;
         lo_q          <= 2'd0;
         size_q        <= 2'd0;
         signext_q     <= 1'b0;
      end else begin
         out_misalign <= 1'b0;
         out_buserr   <= 1'b0;
         if (state == ST_IDLE) begin
            if (start) begin
               out_bus_req   <= 1'b1;
               out_bus_we    <= in_memwrite & ~in_memread;
               out_bus_addr  <= in_R[31:2];
               out_bus_be    <= lane_be;
               out_bus_wdata <= lane_wdata;
               lo_q          <= in_R[1:0];
               size_q        <= in_size;
               signext_q     <= in_signext;
               wait_cnt      <= 8'd0;
            end else if (op) begin
               out_misalign <= 1'b1;
            end
         end else if (state == ST_WAIT) begin
            if (take_ack) begin
               out_bus_req <= 1'b0;
               out_rdata   <= out_bus_we ? 32'd0 : lane_load;
            end else if (timeout) begin
               out_bus_req <= 1'b0;
               out_rdata   <= 32'd0;
               out_buserr  <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire
